// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE, CONV, DONE) as legacy-compatible constants
//   - double-dabble adjust constants (threshold 4, correction 3)
//   - min_digits(): number of decimal digits needed for an unsigned value of
//     a given bit width, used by the converter's elaboration-time check
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CONV = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // ceil(bin_w * log10(2)) using log10(2) ~= 0.30103 in fixed point.
   function automatic int unsigned min_digits(input int unsigned bin_w);
      return (bin_w * 32'd30103 + 32'd99999) / 32'd100000;
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational double-dabble correction cell for one BCD digit:
// dout = (din > 4) ? din + 3 : din, modulo 4 bits.
// Ports:
//   din   in   4  BCD digit before the shift
//   dout  out  4  corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Add 3 to digits of 5 or more so the following shift carries correctly.
   always_comb begin
      dout = din;
      if (din > BCD_ADJ_THRESH) begin
         dout = din + BCD_ADJ_ADD;
      end else begin
         dout = din;
      end
   end

endmodule : bcd_digit_adjust

// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
// Iterative binary-to-BCD converter (double dabble, one bit per clock) with
// valid/ready handshakes on input and output.
// Optional feature macro: SIGNED_INPUT_EN (two's-complement input, adds neg_out).
// Ports:
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           bin_in is valid
//   in_ready   out  1           converter idle and able to accept
//   bin_in     in   BIN_W       value to convert
//   out_valid  out  1           bcd_out is valid
//   out_ready  in   1           consumer accepts bcd_out
//   bcd_out    out  4*DIGITS    packed BCD, ones digit in [3:0]
//   neg_out    out  1           (SIGNED_INPUT_EN only) input was negative
//   busy       out  1           converting or holding a result
// -----------------------------------------------------------------------------
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
`ifdef SIGNED_INPUT_EN
   output logic                  neg_out,
`endif
   output logic                  busy
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = BCD_W + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W) + 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   if (DIGITS < int'(min_digits(BIN_W))) begin : g_digits_check
      $error("bcd_seq_converter: DIGITS too small for BIN_W");
   end

   state_t              state_r;
   logic [WORK_W-1:0]   work_r;
   logic [CNT_W-1:0]    count_r;
   logic [BCD_W-1:0]    bcd_out_r;
   logic                out_valid_r;
   logic                in_ready_r;
   logic                busy_r;
   logic [BIN_W-1:0]    mag_s;
   logic [BCD_W-1:0]    adj_field_s;
   logic [WORK_W-1:0]   shifted_s;
   logic                accept_s;

   assign accept_s = in_valid & in_ready_r;

`ifdef SIGNED_INPUT_EN
   logic neg_r;
   assign neg_out = neg_r;

   // Magnitude of the two's-complement input; the most-negative value maps to
   // itself, which read as unsigned is its full magnitude.
   always_comb begin
      mag_s = bin_in;
      if (bin_in[BIN_W-1]) begin
         mag_s = ~bin_in + {{(BIN_W-1){1'b0}}, 1'b1};
      end else begin
         mag_s = bin_in;
      end
   end

   // Sign flag captured on acceptance, held with the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && accept_s) begin
         neg_r <= bin_in[BIN_W-1];
      end else begin
         neg_r <= neg_r;
      end
   end
`else
   assign mag_s = bin_in;
`endif

   // One correction cell per BCD digit of the working register.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (work_r[BIN_W + 4*g +: 4]),
         .dout (adj_field_s[4*g +: 4])
      );
   end

   // Adjusted BCD field plus untouched binary field, shifted left by one.
   assign shifted_s = {adj_field_s[BCD_W-2:0], work_r[BIN_W-1:0], 1'b0};

   // Converter FSM, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         work_r      <= {WORK_W{1'b0}};
         count_r     <= CNT_ZERO;
         bcd_out_r   <= {BCD_W{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  work_r     <= {{BCD_W{1'b0}}, mag_s};
                  count_r    <= CNT_LOAD;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_CONV;
               end else begin
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
               end
            end
            ST_CONV: begin
               work_r  <= shifted_s;
               count_r <= count_r - CNT_ONE;
               if (count_r == CNT_ZERO) begin
                  bcd_out_r   <= shifted_s[WORK_W-1:BIN_W];
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  out_valid_r <= 1'b0;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               count_r     <= CNT_ZERO;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bcd_out   = bcd_out_r;
   assign out_valid = out_valid_r;
   assign in_ready  = in_ready_r;
   assign busy      = busy_r;

endmodule : bcd_seq_converter

// File: tb/tb_bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_seq_converter
// Directed self-checking bench for bcd_seq_converter (BIN_W=8, DIGITS=3).
// -----------------------------------------------------------------------------
module tb_bcd_seq_converter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  bin_in;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] bcd_out;
   logic        busy;
`ifdef SIGNED_INPUT_EN
   logic        neg_out;
`endif

   int errors = 0;
   int checks = 0;

   bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
`ifdef SIGNED_INPUT_EN
      .neg_out   (neg_out),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decimal model for 0..255.
   function automatic logic [11:0] dec_model(input int v);
      logic [3:0] h, t, o;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   // Drive one conversion: accept v, wait for the result, hold out_ready low
   // for 'hold' extra cycles, then complete the output handshake.
   task automatic run_conv(input logic [7:0] v, input int hold,
                           output logic [11:0] res, output logic neg,
                           output logic tmo);
      int n;
      tmo = 1'b0;
      neg = 1'b0;
      out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      if (!in_ready) tmo = 1'b1;
      bin_in = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bin_in = 8'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      if (!out_valid) tmo = 1'b1;
      for (int i = 0; i < hold; i++) tick();
      res = bcd_out;
`ifdef SIGNED_INPUT_EN
      neg = neg_out;
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin_in = 8'd0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || bcd_out !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b busy=%b bcd_out=%h, required 0 0 000",
                  out_valid, busy, bcd_out);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_latency_255();
      int edge_seen;
      edge_seen = -1;
      out_ready = 1'b1;
      bin_in = 8'd255;
      in_valid = 1'b1;
      tick();                       // acceptance edge
      in_valid = 1'b0;
      bin_in = 8'd0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (out_valid === 1'b1 && edge_seen < 0) begin
            edge_seen = i;
            checks++;
            if (bcd_out !== 12'h255) begin
               errors++;
               $display("FAIL result_255: got %h, required 255", bcd_out);
            end
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_in_done: got %b, required 0", in_ready);
            end
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_handshake: in_ready=%b out_valid=%b, required 1 0",
                        in_ready, out_valid);
            end
            break;
         end
      end
      checks++;
      if (edge_seen != 8) begin
         errors++;
         $display("FAIL latency_255: out_valid after %0d edges, required 8", edge_seen);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_values();
      logic [7:0]  vals [3] = '{8'd0, 8'd99, 8'd100};
      logic [11:0] exps [3] = '{12'h000, 12'h099, 12'h100};
      logic [11:0] res;
      logic neg, tmo;
      for (int i = 0; i < 3; i++) begin
         run_conv(vals[i], 0, res, neg, tmo);
         checks++;
         if (tmo || res !== exps[i]) begin
            errors++;
            $display("FAIL value_%0d: got %h (timeout=%b), required %h",
                     vals[i], res, tmo, exps[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [11:0] res;
      logic neg, tmo;
      out_ready = 1'b0;
      bin_in = 8'd47;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      bin_in = 8'd200;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         tick();
         checks++;
         if (bcd_out !== 12'h047 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: bcd_out=%h out_valid=%b in_ready=%b, required 047 1 0",
                     i, bcd_out, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_hold: out_valid=%b in_ready=%b, required 0 1",
                  out_valid, in_ready);
      end
      run_conv(8'd200, 0, res, neg, tmo);
      checks++;
      if (tmo || res !== 12'h200) begin
         errors++;
         $display("FAIL after_hold_200: got %h (timeout=%b), required 200", res, tmo);
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] res;
      logic neg, tmo;
      bin_in = 8'd123;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || bcd_out !== 12'h000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out_valid=%b bcd_out=%h busy=%b, required 0 000 0",
                  out_valid, bcd_out, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      run_conv(8'd123, 0, res, neg, tmo);
      checks++;
      if (tmo || res !== 12'h123) begin
         errors++;
         $display("FAIL after_reset_123: got %h (timeout=%b), required 123", res, tmo);
      end
   endtask

   task automatic test_sweep();
      logic [11:0] res;
      logic neg, tmo;
      for (int v = 0; v < 256; v++) begin
         run_conv(8'(v), int'($urandom_range(0, 3)), res, neg, tmo);
         checks++;
         if (tmo || res !== dec_model(v) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_%0d: got %h out_valid=%b (timeout=%b), required %h 0",
                     v, res, out_valid, tmo, dec_model(v));
         end
      end
   endtask

`ifdef SIGNED_INPUT_EN
   task automatic test_signed();
      logic [7:0]  vals [3] = '{8'hFF, 8'h80, 8'h7F};
      logic [11:0] exps [3] = '{12'h001, 12'h128, 12'h127};
      logic        negs [3] = '{1'b1, 1'b1, 1'b0};
      logic [11:0] res;
      logic neg, tmo;
      for (int i = 0; i < 3; i++) begin
         run_conv(vals[i], 0, res, neg, tmo);
         checks++;
         if (tmo || res !== exps[i] || neg !== negs[i]) begin
            errors++;
            $display("FAIL signed_%h: got neg=%b %h, required neg=%b %h",
                     vals[i], neg, res, negs[i], exps[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latency_255();
      test_values();
      test_backpressure();
      test_async_reset();
`ifdef SIGNED_INPUT_EN
      test_signed();
`else
      test_sweep();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bcd_seq_converter

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Iterative binary-to-BCD converter for the calculator display path. It runs the double-dabble algorithm: one bit per clock, with a per-digit "add 3 if >4" adjust stage applied before each shift. It sits between the ALU result register and the seven-segment digit mux. Valid/ready handshakes are used on both sides.

Parameters:
BIN_W, 8, width of the unsigned binary input.
DIGITS, 3, number of BCD output digits. Must be at least ceil(BIN_W*log10(2)); an elaboration-time check fails otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  bin_in is valid.
in_ready  output  1  converter can accept a value; high only in IDLE.
bin_in  input  BIN_W  binary value to convert.
out_valid  output  1  bcd_out is valid.
out_ready  input  1  consumer accepts bcd_out.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) is in [3:0].
busy  output  1  high in CONV or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - shift register, bit counter and bcd_out all cleared to 0.
  - out_valid=0, busy=0, in_ready=1 once rst_n deasserts.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On an edge with in_valid&&in_ready:
  - load bin_in into the low BIN_W bits of the working register;
  - clear the BCD field and set count=BIN_W-1;
  - go to CONV.
- CONV: in_ready=0, busy=1. Each cycle:
  - every BCD digit d of the working register is replaced by (d>4 ? d+3 : d), modulo 4 bits (d+3 never exceeds 12 for legal digits);
  - the whole register (BCD field and binary field) is then shifted left by 1;
  - count decrements.
  - When count==0 at the edge, the final shifted BCD field is registered into bcd_out, out_valid is set, and the FSM goes to DONE.
- Latency: out_valid rises exactly BIN_W rising edges after the acceptance edge.
- DONE: out_valid=1, and bcd_out holds stable until the handshake. On out_valid&&out_ready, out_valid clears and the FSM returns to IDLE. in_ready reasserts in the next cycle; there is no same-cycle pass-through.
- in_valid while not in IDLE is ignored. bin_in need not stay stable after acceptance.
- out_ready held low keeps the FSM in DONE indefinitely, with no loss or corruption of the result.
- Reset asserted mid-CONV or in DONE aborts immediately to the reset values; the partial result is discarded.
- Width rules:
  - working register width = 4*DIGITS+BIN_W;
  - counter width = $clog2(BIN_W)+1;
  - input 0 yields all-zero digits; input 2^BIN_W-1 yields the exact decimal value (255 -> 2,5,5 for defaults).
- Unused high digits are always 0.

Optional Feature:
Macro SIGNED_INPUT_EN.
- Defined:
  - bin_in is treated as two's complement;
  - a new output port neg_out (1 bit) is added, registered on acceptance as bin_in[BIN_W-1];
  - the magnitude (two's-complement negate when negative) is loaded instead of the raw value;
  - the most-negative value converts to its full magnitude (8'h80 -> 128);
  - neg_out resets to 0 and is valid together with out_valid.
- Not defined: no neg_out port, input is unsigned, logic is identical to the unsigned description.

Decomposition:
- Shared package bcd_pkg:
  - FSM state enum (IDLE, CONV, DONE);
  - constant BCD_ADJ_THRESH=4 and BCD_ADJ_ADD=3;
  - function computing minimum DIGITS from BIN_W, used by the elaboration check.
- Sub-module bcd_digit_adjust: 4-bit in, 4-bit out, combinational add-3-if-greater-than-4 cell. It is instantiated DIGITS times in a generate loop on the BCD field of the working register.

Test Plan:
- Apply reset, then present 8'd255 with in_valid=1, out_ready=1 -> out_valid high exactly 8 edges after acceptance, bcd_out=12'h255, then in_ready=1 the following cycle.
- Input 8'd0 -> bcd_out=12'h000. Input 8'd99 -> bcd_out=12'h099. Input 8'd100 -> bcd_out=12'h100.
- Accept 8'd47 while holding out_ready=0 for 20 cycles, and toggle in_valid with 8'd200 during that window:
  - bcd_out stays 12'h047, out_valid stays 1, in_ready stays 0;
  - after out_ready=1, the next accepted value, 8'd200, yields 12'h200.
- Assert rst_n=0 four edges into a conversion of 8'd123 -> out_valid=0, bcd_out=0 and busy=0 immediately (asynchronous); after release, 8'd123 converts cleanly to 12'h123.
- Exhaustive sweep 0..255 with random out_ready back-pressure -> every result matches a reference decimal model, with no dropped or duplicated outputs.
- With SIGNED_INPUT_EN defined:
  - 8'hFF -> neg_out=1, 12'h001;
  - 8'h80 -> neg_out=1, 12'h128;
  - 8'h7F -> neg_out=0, 12'h127.
